// File: rtl/bist_pattern_gen_misr.sv
// bist_pattern_gen_misr: BIST harness for a combinational benchmark netlist.
// A 9-bit LFSR produces input vectors, which are issued with a valid/ready
// handshake. The returned output vectors are compacted into a PO_W-bit MISR.
// Optional build macro BIST_GOLDEN_CMP_EN compares the final signature against
// the golden input. Without the macro, pass is tied to 0 and golden is unused.
module bist_pattern_gen_misr #(
  parameter int              PI_W      = 9,
  parameter int              PO_W      = 49,
  parameter int              NUM_PAT   = 256,
  parameter logic [8:0]      SEED      = 9'h1FF,
  parameter logic [PO_W-1:0] MISR_TAPS = 49'h1_0000_0000_0100,
  parameter int              MAX_OUT   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PI_W-1:0] pat_out,
  output logic            pat_valid,
  input  logic            pat_ready,
  input  logic [PO_W-1:0] resp_in,
  input  logic            resp_valid,
  input  logic [PO_W-1:0] golden,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [PO_W-1:0] signature,
  output logic            err_ovf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEED  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // An all-zero seed would lock the LFSR, so it is replaced with 1.
  localparam logic [8:0]  SEED_EFF  = (SEED == 9'h000) ? 9'h001 : SEED;
  localparam logic [15:0] NUM_PAT_W = 16'(NUM_PAT);
  localparam logic [15:0] MAX_OUT_W = 16'(MAX_OUT);

  logic [2:0]      state;
  logic [8:0]      lfsr;
  logic [PO_W-1:0] misr;
  logic [15:0]     issued;
  logic [15:0]     received;
  logic [15:0]     outstanding;
  logic            accept;
  logic            resp_take;
  logic            pass_q;

  // Handshake and status decode come straight from registered state.
  assign pat_valid = (state == S_RUN) && (issued < NUM_PAT_W) && (outstanding < MAX_OUT_W);
  assign pat_out   = (state == S_IDLE) ? '0 : PI_W'(lfsr);
  assign accept    = pat_valid && pat_ready;
  assign resp_take = resp_valid && (state != S_IDLE) && (state != S_SEED);
  assign busy      = (state == S_SEED) || (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign signature = misr;

`ifdef BIST_GOLDEN_CMP_EN
  assign pass = pass_q;
`else
  // Golden is not consumed in this build; fold it into a named sink.
  logic golden_unused;
  assign golden_unused = ^golden;
  assign pass = 1'b0;
`endif

  // Sequencer, LFSR, MISR and counters.
  // NOTE: every register here uses non-blocking assignment so all updates in a
  // cycle see the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      lfsr        <= SEED_EFF;
      misr        <= '0;
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
      pass_q      <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      if (accept) begin
        lfsr   <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        issued <= issued + 16'd1;
      end

      if (resp_take) begin
        misr <= {misr[PO_W-2:0], ^(misr & MISR_TAPS)} ^ resp_in;
        if (received != NUM_PAT_W) received <= received + 16'd1;
        if (outstanding == 16'd0) err_ovf <= 1'b1;
      end

      // Simultaneous accept and response leave the count unchanged. A response
      // with nothing outstanding is an error and does not underflow the count.
      if (accept && !resp_take)
        outstanding <= outstanding + 16'd1;
      else if (!accept && resp_take && outstanding != 16'd0)
        outstanding <= outstanding - 16'd1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) state <= S_SEED;
        end
        S_SEED: begin
          lfsr        <= SEED_EFF;
          misr        <= '0;
          issued      <= '0;
          received    <= '0;
          outstanding <= '0;
          pass_q      <= 1'b0;
          err_ovf     <= 1'b0;
          state       <= S_RUN;
        end
        S_RUN: begin
          if (accept && issued == NUM_PAT_W - 16'd1) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (received == NUM_PAT_W) begin
            state <= S_DONE;
`ifdef BIST_GOLDEN_CMP_EN
            pass_q <= (misr == golden);
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_pattern_gen_misr.sv
// Self-checking bench for bist_pattern_gen_misr (default parameters).
// Accepted patterns go into scoreboard queues. They are looped back one cycle
// later as responses, and a reference LFSR/MISR predicts patterns and signature.
module tb_bist_pattern_gen_misr;
  localparam int         PI_W = 9;
  localparam int         PO_W = 49;
  localparam int         NPAT = 256;
  localparam logic [48:0] TAPS = 49'h1_0000_0000_0100;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [PI_W-1:0] pat_out;
  logic            pat_valid;
  logic            pat_ready;
  logic [PO_W-1:0] resp_in;
  logic            resp_valid;
  logic [PO_W-1:0] golden;
  logic            busy;
  logic            done;
  logic            pass;
  logic [PO_W-1:0] signature;
  logic            err_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]  model_lfsr;
  logic [48:0] model_misr;
  logic [8:0]  dut_q[$];
  logic [8:0]  model_q[$];
  int          accepted;
  logic [48:0] sig1;

  bist_pattern_gen_misr dut (
    .clk(clk), .rst(rst), .start(start), .pat_out(pat_out), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .resp_in(resp_in), .resp_valid(resp_valid), .golden(golden),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [48:0] misr_step(input logic [48:0] m, input logic [48:0] r);
    return {m[47:0], ^(m & TAPS)} ^ r;
  endfunction

  // One clock: at the falling edge, drive the loopback response and ready,
  // then score any pattern that will be accepted at the next rising edge.
  task automatic cycle(input logic ready, input logic respond);
    logic [8:0] p;
    logic [8:0] m;
    @(negedge clk);
    start = 1'b0;
    if (respond && dut_q.size() > 0) begin
      p = dut_q.pop_front();
      m = model_q.pop_front();
      resp_valid = 1'b1;
      resp_in    = {40'b0, p};
      model_misr = misr_step(model_misr, {40'b0, m});
    end else begin
      resp_valid = 1'b0;
      resp_in    = '0;
    end
    pat_ready = ready;
    if (pat_valid && ready) begin
      n_checks++;
      if (pat_out !== model_lfsr) begin
        n_fail++;
        $display("FAIL pattern[%0d]: got %h expected %h", accepted, pat_out, model_lfsr);
      end
      dut_q.push_back(pat_out);
      model_q.push_back(model_lfsr);
      model_lfsr = {model_lfsr[7:0], model_lfsr[8] ^ model_lfsr[4]};
      accepted++;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start      = 1'b1;
    pat_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_in    = '0;
    model_lfsr = 9'h1FF;
    model_misr = '0;
    dut_q.delete();
    model_q.delete();
    accepted   = 0;
  endtask

  // Run with ready and loopback until done, then check the end-of-run state.
  task automatic finish_run(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", tag, done, n);
    end
    n_checks++;
    if (accepted != NPAT) begin
      n_fail++;
      $display("FAIL %s_count: accepted %0d, required %0d", tag, accepted, NPAT);
    end
    n_checks++;
    if (signature !== model_misr) begin
      n_fail++;
      $display("FAIL %s_signature: got %h required %h", tag, signature, model_misr);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy: got %b required 0", tag, busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({pat_out, pat_valid, busy, done, pass, signature, err_ovf} !== '0) begin
      n_fail++;
      $display("FAIL %s: pat_out=%h pat_valid=%b busy=%b done=%b pass=%b sig=%h err_ovf=%b, required all 0",
               tag, pat_out, pat_valid, busy, done, pass, signature, err_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pat_ready = 1'b0; resp_valid = 1'b0; resp_in = '0;
    golden = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_full_run();
    do_start();
    cycle(1'b1, 1'b1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_busy: got %b required 1", busy);
    end
    finish_run("full_run");
    sig1 = model_misr;
`ifndef BIST_GOLDEN_CMP_EN
    n_checks++;
    if (pass !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_disabled: got %b required 0", pass);
    end
`endif
  endtask

  task automatic test_stall_and_max_out();
    int a0;
    do_start();
    repeat (50) cycle(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1);
      n_checks++;
      if (pat_valid !== 1'b1 || pat_out !== model_lfsr) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b pat_out=%h, required 1/%h", i, pat_valid, pat_out, model_lfsr);
      end
    end
    a0 = accepted;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
    n_checks++;
    if (accepted - a0 != 4) begin
      n_fail++;
      $display("FAIL max_out_count: accepted %0d, required 4", accepted - a0);
    end
    n_checks++;
    if (pat_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL max_out_valid: got %b required 0", pat_valid);
    end
    finish_run("stall_run");
    n_checks++;
    if (signature !== sig1) begin
      n_fail++;
      $display("FAIL stall_sig_repeat: got %h required %h", signature, sig1);
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    resp_valid = 1'b1;
    resp_in    = 49'h1_2345_6789_ABCD;
    model_misr = misr_step(model_misr, 49'h1_2345_6789_ABCD);
    @(negedge clk);
    resp_valid = 1'b0;
    resp_in    = '0;
    n_checks++;
    if (err_ovf !== 1'b1 || signature !== model_misr) begin
      n_fail++;
      $display("FAIL overflow: err_ovf=%b sig=%h, required 1/%h", err_ovf, signature, model_misr);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (err_ovf !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: err_ovf=%b done=%b, required 1/1", err_ovf, done);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    n_checks++;
    if (err_ovf !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: err_ovf=%b done=%b, required 0/0", err_ovf, done);
    end
    finish_run("restart_run");
  endtask

  task automatic test_reset_midrun();
    int n;
    do_start();
    n = 0;
    while (accepted < 100 && n < 1000) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    @(negedge clk);
    rst = 1'b1; pat_ready = 1'b0; resp_valid = 1'b0; resp_in = '0;
    @(negedge clk);
    check_all_zero("reset_midrun");
    rst = 1'b0;
    do_start();
    finish_run("post_reset_run");
    n_checks++;
    if (signature !== sig1) begin
      n_fail++;
      $display("FAIL post_reset_sig_repeat: got %h required %h", signature, sig1);
    end
  endtask

`ifdef BIST_GOLDEN_CMP_EN
  task automatic test_golden();
    golden = sig1;
    do_start();
    finish_run("golden_match");
    n_checks++;
    if (pass !== 1'b1) begin
      n_fail++;
      $display("FAIL golden_match_pass: got %b required 1", pass);
    end
    golden = sig1 ^ 49'h1;
    do_start();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    n_checks++;
    if (pass !== 1'b0) begin
      n_fail++;
      $display("FAIL golden_seed_clear: got %b required 0", pass);
    end
    finish_run("golden_flip");
    n_checks++;
    if (pass !== 1'b0) begin
      n_fail++;
      $display("FAIL golden_flip_pass: got %b required 0", pass);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_stall_and_max_out();
    test_overflow();
    test_back_to_back();
    test_reset_midrun();
`ifdef BIST_GOLDEN_CMP_EN
    test_golden();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_pattern_gen_misr.md
Name: bist_pattern_gen_misr

Overview:
- Self-test harness for the generated combinational benchmark netlists: the driving/reading end of a DUT's primary-input/primary-output interface.
- Generates pseudo-random input vectors with an LFSR, issues them with a valid handshake, and compacts returned output vectors into a MISR signature.
- Sits beside each benchmark instance (9 PI / 49 PO class) and reports busy/done/signature to the test controller.

Parameters:
- PI_W, 9, DUT primary-input width; 9-bit LFSR is fixed, so only 9 is legal.
- PO_W, 49, DUT primary-output width; MISR width.
- NUM_PAT, 256, patterns per run; legal range 1..65535.
- SEED, 9'h1FF, LFSR seed; 0 is replaced by 9'h001.
- MISR_TAPS, 49'h1_0000_0000_0100, MISR feedback mask (bits 48 and 8).
- MAX_OUT, 4, maximum outstanding patterns without a returned response (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- pat_out  out  PI_W  pattern to DUT inputs
- pat_valid  out  1  pat_out valid this cycle
- pat_ready  in  1  DUT side accepts pat_out
- resp_in  in  PO_W  DUT output vector
- resp_valid  in  1  resp_in valid; one per accepted pattern, in order
- golden  in  PO_W  expected signature (used only with the optional feature)
- busy  out  1  high in SEED, RUN, DRAIN
- done  out  1  high in DONE
- pass  out  1  signature compare result
- signature  out  PO_W  MISR contents
- err_ovf  out  1  sticky; response arrived with zero outstanding

Behaviour:
- Reset values: pat_out=0, pat_valid=0, busy=0, done=0, pass=0, signature=0, err_ovf=0. Internal state: IDLE, counters 0, LFSR=SEED.
- FSM states: IDLE, SEED, RUN, DRAIN, DONE.
  - IDLE/DONE + start -> SEED. Start is ignored in other states.
  - SEED (1 cycle): lfsr<=SEED (or 1 if SEED=0), misr<=0, issued<=0, received<=0, outstanding<=0, done<=0, pass<=0, err_ovf<=0 -> RUN.
  - RUN: pat_valid=1 when issued<NUM_PAT and outstanding<MAX_OUT; pat_out=lfsr.
    - Acceptance = pat_valid & pat_ready.
    - On acceptance: lfsr<={lfsr[7:0], lfsr[8]^lfsr[4]}, issued++.
    - Move to DRAIN when issued reaches NUM_PAT.
  - DRAIN: pat_valid=0; wait until received==NUM_PAT -> DONE.
  - DONE: done=1, busy=0; signature holds.
- pat_out and pat_valid are combinational from registered state. pat_out holds the current LFSR value whenever pat_valid=0.
- Response handling, in any state except IDLE/SEED: on resp_valid, misr<={misr[PO_W-2:0], ^(misr & MISR_TAPS)} ^ resp_in, received++.
- resp_valid in IDLE/SEED is ignored.
- outstanding update: +1 on acceptance, -1 on response, unchanged when both occur in the same cycle.
- A response with outstanding==0 sets err_ovf; the MISR still updates, and received saturates at NUM_PAT.
- Latency: MISR update is visible on signature the cycle after resp_valid. done rises the cycle after the final response is registered.
- Counters are 16 bits. The LFSR is maximal length, period 511; for NUM_PAT>511 patterns repeat.
- rst mid-run returns to IDLE with all reset values, regardless of outstanding count.

Optional Feature:
- Macro: BIST_GOLDEN_CMP_EN.
- Defined: on entering DONE, pass<=(misr==golden); pass is cleared in SEED.
- Undefined: golden is ignored and pass is constant 0. No comparator is built.

Test Plan:
- rst high 2 cycles, then start with pat_ready=1 and 1-cycle loopback resp_in={40'b0,pat_out} -> first pat_out=9'h1FF, second 9'h1FE. done after NUM_PAT=256 responses; signature matches the bench model.
- Hold pat_ready=0 for 10 cycles mid-run -> pat_out frozen, no LFSR advance, issued unchanged.
- MAX_OUT=4 with responses withheld -> exactly 4 acceptances, then pat_valid=0 until a response arrives.
- Inject resp_valid in DONE with zero outstanding -> err_ovf=1 and sticky until next SEED.
- Assert rst in RUN after 100 patterns -> next cycle all outputs 0. A subsequent start reproduces the first-run signature.
- BIST_GOLDEN_CMP_EN with golden = model signature -> pass=1; flip golden bit 0 -> pass=0.
